// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction field positions and decoded-flag type
// for the decode stage and its scoreboard.
package decode_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int REG_MSB    = 25;
    localparam int REG_LSB    = 21;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_NOP = 6'h00;
    localparam opcode_t OP_INC = 6'h01;
    localparam opcode_t OP_LW  = 6'h02;
    localparam opcode_t OP_SW  = 6'h03;

    typedef struct packed {
        logic inc;
        logic lw;
        logic sw;
        logic illegal;
    } dec_flags_t;

    function automatic dec_flags_t decode_op(input opcode_t op);
        dec_flags_t f;
        f = '0;
        case (op)
            OP_NOP:  ;
            OP_INC:  f.inc = 1'b1;
            OP_LW:   f.lw  = 1'b1;
            OP_SW:   f.sw  = 1'b1;
            default: f.illegal = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-thread register busy bits: set on issue of a register writer, cleared on
// writeback. Set beats clear on the same bit; register 0 never becomes busy.
module reg_scoreboard #(
    parameter int THREAD_BITS = 3,
    parameter int REG_BITS    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en_i,
    input  logic [THREAD_BITS-1:0] set_thread_i,
    input  logic [REG_BITS-1:0]    set_reg_i,
    input  logic                   clr_en_i,
    input  logic [THREAD_BITS-1:0] clr_thread_i,
    input  logic [REG_BITS-1:0]    clr_reg_i,
    input  logic [THREAD_BITS-1:0] rd_thread_i,
    input  logic [REG_BITS-1:0]    rd_reg_i,
    output logic                   rd_busy_o
);

    localparam int ENTRIES = 1 << (THREAD_BITS + REG_BITS);

    logic [ENTRIES-1:0] busy_q, busy_d;

    // Readers see the pre-update value: no same-cycle writeback bypass.
    assign rd_busy_o = busy_q[{rd_thread_i, rd_reg_i}];

    // NOTE: every variable in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i)
            busy_d[{clr_thread_i, clr_reg_i}] = 1'b0;
        if (set_en_i && (set_reg_i != '0))
            busy_d[{set_thread_i, set_reg_i}] = 1'b1;
    end

    // NOTE: the whole bit array is reset because hazards must be clear after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: holds one fetched instruction, decodes it, drives the register
// file read address and stalls on per-thread read-after-write hazards.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_WIDTH       = 32,
    parameter int IMMEDIATE_WIDTH   = 16,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTR_WIDTH-1:0]       in_instruction,
    input  logic [THREAD_INDEX_BITS-1:0] in_thread_index,
    input  logic                         flush_valid,
    input  logic [THREAD_INDEX_BITS-1:0] flush_thread_index,
    input  logic                         wb_valid,
    input  logic [THREAD_INDEX_BITS-1:0] wb_thread_index,
    input  logic [REG_INDEX_BITS-1:0]    wb_reg_index,
    output logic [REG_INDEX_BITS-1:0]    rf_read_index,
    output logic [THREAD_INDEX_BITS-1:0] rf_read_thread,
    output logic                         out_increment_flag,
    output logic                         out_load_word_flag,
    output logic                         out_store_word_flag,
    output logic [IMMEDIATE_WIDTH-1:0]   out_immediate,
    output logic [REG_INDEX_BITS-1:0]    out_reg_index,
    output logic [THREAD_INDEX_BITS-1:0] out_thread_index,
    output logic                         out_illegal,
    output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

    logic                         held_valid_q, held_valid_d;
    logic [INSTR_WIDTH-1:0]       held_instr_q, held_instr_d;
    logic [THREAD_INDEX_BITS-1:0] held_thread_q, held_thread_d;
    logic [STALL_COUNT_WIDTH-1:0] stall_q, stall_d;

    opcode_t                   opcode;
    logic [REG_INDEX_BITS-1:0] held_reg;
    dec_flags_t                dec, issued;
    logic                      reg_busy, hazard, flush_hit, issue, capture;

    assign opcode   = held_instr_q[OPCODE_MSB:OPCODE_LSB];
    assign held_reg = held_instr_q[REG_MSB:REG_LSB];
    assign dec      = decode_op(opcode);

    assign hazard    = held_valid_q && (dec.inc || dec.sw) && reg_busy;
    assign flush_hit = flush_valid && held_valid_q && (held_thread_q == flush_thread_index);
    assign issue     = held_valid_q && !hazard && !flush_hit;
    assign in_ready  = !held_valid_q || issue || flush_hit;
    assign capture   = in_valid && in_ready;
    assign issued    = issue ? dec : '0;

    assign rf_read_index       = held_reg;
    assign rf_read_thread      = held_thread_q;
    assign out_reg_index       = held_reg;
    assign out_thread_index    = held_thread_q;
    assign out_immediate       = held_instr_q[IMM_MSB:IMM_LSB];
    assign out_increment_flag  = issued.inc;
    assign out_load_word_flag  = issued.lw;
    assign out_store_word_flag = issued.sw;
    assign out_illegal         = issued.illegal;
    assign stall_count         = stall_q;

    reg_scoreboard #(
        .THREAD_BITS (THREAD_INDEX_BITS),
        .REG_BITS    (REG_INDEX_BITS)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .set_en_i     (issue && (dec.inc || dec.lw)),
        .set_thread_i (held_thread_q),
        .set_reg_i    (held_reg),
        .clr_en_i     (wb_valid),
        .clr_thread_i (wb_thread_index),
        .clr_reg_i    (wb_reg_index),
        .rd_thread_i  (held_thread_q),
        .rd_reg_i     (held_reg),
        .rd_busy_o    (reg_busy)
    );

    always_comb begin
        held_valid_d  = held_valid_q;
        held_instr_d  = held_instr_q;
        held_thread_d = held_thread_q;
        stall_d       = stall_q;
        // A new capture replaces whatever left via issue or flush this cycle.
        if (capture) begin
            held_valid_d  = 1'b1;
            held_instr_d  = in_instruction;
            held_thread_d = in_thread_index;
        end else if (issue || flush_hit) begin
            held_valid_d  = 1'b0;
        end
        if (hazard && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_valid_q  <= 1'b0;
            held_instr_q  <= '0;
            held_thread_q <= '0;
            stall_q       <= '0;
        end else begin
            held_valid_q  <= held_valid_d;
            held_instr_q  <= held_instr_d;
            held_thread_q <= held_thread_d;
            stall_q       <= stall_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: issue, RAW stall, thread isolation,
// illegal opcodes, flush with same-cycle capture, register 0 and async reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [2:0]  in_thread_index;
    logic        flush_valid;
    logic [2:0]  flush_thread_index;
    logic        wb_valid;
    logic [2:0]  wb_thread_index;
    logic [4:0]  wb_reg_index;
    logic [4:0]  rf_read_index;
    logic [2:0]  rf_read_thread;
    logic        out_increment_flag;
    logic        out_load_word_flag;
    logic        out_store_word_flag;
    logic [15:0] out_immediate;
    logic [4:0]  out_reg_index;
    logic [2:0]  out_thread_index;
    logic        out_illegal;
    logic [15:0] stall_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_instruction      (in_instruction),
        .in_thread_index     (in_thread_index),
        .flush_valid         (flush_valid),
        .flush_thread_index  (flush_thread_index),
        .wb_valid            (wb_valid),
        .wb_thread_index     (wb_thread_index),
        .wb_reg_index        (wb_reg_index),
        .rf_read_index       (rf_read_index),
        .rf_read_thread      (rf_read_thread),
        .out_increment_flag  (out_increment_flag),
        .out_load_word_flag  (out_load_word_flag),
        .out_store_word_flag (out_store_word_flag),
        .out_immediate       (out_immediate),
        .out_reg_index       (out_reg_index),
        .out_thread_index    (out_thread_index),
        .out_illegal         (out_illegal),
        .stall_count         (stall_count)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] r,
                                       input logic [15:0] imm);
        return {op, r, 5'b0, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {inc, lw, sw, illegal}.
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {28'b0, out_increment_flag, out_load_word_flag,
                  out_store_word_flag, out_illegal}, {28'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] r, input logic [15:0] imm,
                        input logic [2:0] t);
        in_valid        = 1'b1;
        in_instruction  = mk(op, r, imm);
        in_thread_index = t;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_instruction = '0; in_thread_index = '0;
        flush_valid = 1'b0; flush_thread_index = '0;
        wb_valid = 1'b0; wb_thread_index = '0; wb_reg_index = '0;
        #12;
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk_flags("rst_flags", 4'b0000);
        chk("rst_stall", {16'b0, stall_count}, 32'd0);
        reset = 1'b1;

        // INC r3 thread 2, imm 5.
        step(); send(6'h01, 5'd3, 16'h0005, 3'd2);
        step(); in_valid = 1'b0;
        chk_flags("inc_flags", 4'b1000);
        chk("inc_reg", {27'b0, out_reg_index}, 32'd3);
        chk("inc_thread", {29'b0, out_thread_index}, 32'd2);
        chk("inc_imm", {16'b0, out_immediate}, 32'h5);
        chk("inc_rf_idx", {27'b0, rf_read_index}, 32'd3);
        chk("inc_rf_thr", {29'b0, rf_read_thread}, 32'd2);

        // SW r3 thread 2 right behind it: stalls until writeback.
        send(6'h03, 5'd3, 16'h0000, 3'd2);
        step(); in_valid = 1'b0;
        chk_flags("sw_stall0_flags", 4'b0000);
        chk("sw_stall0_ready", {31'b0, in_ready}, 32'd0);
        chk("sw_stall0_cnt", {16'b0, stall_count}, 32'd0);
        step();
        chk("sw_stall1_cnt", {16'b0, stall_count}, 32'd1);
        chk("sw_stall1_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk("sw_stall2_cnt", {16'b0, stall_count}, 32'd2);
        chk_flags("sw_stall2_flags", 4'b0000);
        wb_valid = 1'b1; wb_thread_index = 3'd2; wb_reg_index = 5'd3;
        #1;
        chk_flags("sw_wb_nobypass", 4'b0000);
        step(); wb_valid = 1'b0;
        chk_flags("sw_issue_flags", 4'b0010);
        chk("sw_issue_ready", {31'b0, in_ready}, 32'd1);
        chk("sw_issue_cnt", {16'b0, stall_count}, 32'd3);

        // Re-mark [2][3] busy, then SW r3 on thread 4 must not stall.
        send(6'h01, 5'd3, 16'h0010, 3'd2);
        step();
        chk_flags("inc2_flags", 4'b1000);
        send(6'h03, 5'd3, 16'h0000, 3'd4);
        step(); in_valid = 1'b0;
        chk_flags("iso_flags", 4'b0010);
        chk("iso_thread", {29'b0, out_thread_index}, 32'd4);
        chk("iso_cnt", {16'b0, stall_count}, 32'd3);

        // Illegal opcode 0x3F on r5 thread 2.
        send(6'h3F, 5'd5, 16'hABCD, 3'd2);
        step(); in_valid = 1'b0;
        chk_flags("ill_flags", 4'b0001);
        chk("ill_ready", {31'b0, in_ready}, 32'd1);
        chk("ill_imm", {16'b0, out_immediate}, 32'hABCD);
        step();
        chk_flags("ill_pulse_end", 4'b0000);
        send(6'h03, 5'd5, 16'h0000, 3'd2);
        step(); in_valid = 1'b0;
        chk_flags("ill_sb_clean", 4'b0010);

        // Stalled SW t2, then flush t2 while LW r7 t1 arrives.
        send(6'h03, 5'd3, 16'h0000, 3'd2);
        step(); in_valid = 1'b0;
        chk_flags("fl_stall_flags", 4'b0000);
        chk("fl_stall_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk("fl_stall_cnt", {16'b0, stall_count}, 32'd4);
        flush_valid = 1'b1; flush_thread_index = 3'd2;
        send(6'h02, 5'd7, 16'h0077, 3'd1);
        #1;
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        chk_flags("fl_bubble", 4'b0000);
        step(); flush_valid = 1'b0; in_valid = 1'b0;
        chk_flags("fl_lw_flags", 4'b0100);
        chk("fl_lw_thread", {29'b0, out_thread_index}, 32'd1);
        chk("fl_lw_reg", {27'b0, out_reg_index}, 32'd7);
        chk("fl_cnt", {16'b0, stall_count}, 32'd5);
        // [1][7] now busy: INC r7 t1 must stall until writeback.
        send(6'h01, 5'd7, 16'h0001, 3'd1);
        step(); in_valid = 1'b0;
        chk_flags("sb17_stall", 4'b0000);
        chk("sb17_ready", {31'b0, in_ready}, 32'd0);
        wb_valid = 1'b1; wb_thread_index = 3'd1; wb_reg_index = 5'd7;
        step(); wb_valid = 1'b0;
        chk_flags("sb17_issue", 4'b1000);
        chk("sb17_cnt", {16'b0, stall_count}, 32'd6);

        // Register 0 is never busy.
        send(6'h02, 5'd0, 16'h0000, 3'd5);
        step();
        chk_flags("r0_lw", 4'b0100);
        send(6'h03, 5'd0, 16'h0000, 3'd5);
        step(); in_valid = 1'b0;
        chk_flags("r0_sw", 4'b0010);
        chk("r0_cnt", {16'b0, stall_count}, 32'd6);

        // Reset mid-stall ([2][3] is still busy).
        send(6'h03, 5'd3, 16'h0000, 3'd2);
        step(); in_valid = 1'b0;
        chk("rs_ready_pre", {31'b0, in_ready}, 32'd0);
        step();
        chk("rs_cnt_pre", {16'b0, stall_count}, 32'd7);
        reset = 1'b0;
        #1;
        chk_flags("rs_flags", 4'b0000);
        chk("rs_cnt", {16'b0, stall_count}, 32'd0);
        chk("rs_ready", {31'b0, in_ready}, 32'd1);
        step();
        reset = 1'b1;
        #1;
        chk("rs_ready_post", {31'b0, in_ready}, 32'd1);
        send(6'h03, 5'd3, 16'h0000, 3'd2);
        step(); in_valid = 1'b0;
        chk_flags("rs_sb_clear", 4'b0010);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
